// File: rtl/wb4_slave_mem.sv
// Wishbone B4 responder memory: 2**AW byte-writable 32-bit words.
// Serves classic cycles and linear/wrapping incrementing bursts, with programmable wait states.
module wb4_slave_mem #(
    parameter int unsigned AW          = 10,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [1:0]  wb_bte_i,
    input  logic [2:0]  wb_cti_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT        = 2'd1,
        S_CLASSIC_ACK = 2'd2,
        S_BURST       = 2'd3
    } state_t;

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   dat_q;
    logic [3:0]    wait_q;
    logic [AW-1:0] word_q;
    logic [1:0]    bte_q;
    logic [31:0]   mem [DEPTH];

    // Handshake: a beat transfers on the rising edge where cyc, stb and the registered
    // ack are all high; the master holds adr/we/sel/dat stable until it samples ack or err.
    logic          req;
    logic          in_win;
    logic          is_burst;
    logic          is_eob;
    logic          launch;
    logic          beat_done;
    logic          wr_en;
    logic [AW-1:0] adr_word;
    logic [AW-1:0] word_nxt;
    logic          unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign in_win     = (wb_adr_i[31:AW+2] == BASE_ADR[31:AW+2]);
    assign adr_word   = wb_adr_i[AW+1:2];
    assign is_burst   = (wb_cti_i == 3'b010);
    assign is_eob     = (wb_cti_i == 3'b111);
    assign unused_adr = ^wb_adr_i[1:0];

    assign launch = req & (((state_q == S_IDLE) && (WAIT_CYCLES == 0)) ||
                           ((state_q == S_WAIT) && (wait_q == 4'd0)));

    // ack_q is only ever set in CLASSIC_ACK or BURST, so this marks a completed beat.
    assign beat_done = ack_q & req;
    assign wr_en     = beat_done & wb_we_i;

    // Wrapping bursts only advance the low log2(N) bits; linear wraps at the window size.
    function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w, input logic [1:0] bte);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        case (bte)
            2'b01:   mask = AW'(3);
            2'b10:   mask = AW'(7);
            2'b11:   mask = AW'(15);
            default: mask = '1;
        endcase
        inc = w + AW'(1);
        return (w & ~mask) | (inc & mask);
    endfunction

    assign word_nxt = next_word(word_q, bte_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) mem[word_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            wait_q  <= '0;
            word_q  <= '0;
            bte_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            if (launch) begin
                word_q <= adr_word;
                bte_q  <= wb_bte_i;
                if (!in_win) begin
                    err_q   <= 1'b1;
                    state_q <= S_CLASSIC_ACK;
                end else begin
                    ack_q   <= 1'b1;
                    dat_q   <= mem[adr_word];
                    state_q <= is_burst ? S_BURST : S_CLASSIC_ACK;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req) begin
                            state_q <= S_WAIT;
                            wait_q  <= WAIT_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (!wb_cyc_i) begin
                            state_q <= S_IDLE;
                        end else if (wb_stb_i) begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                    S_CLASSIC_ACK: begin
                        state_q <= S_IDLE;
                    end
                    S_BURST: begin
                        if (!wb_cyc_i) begin
                            state_q <= S_IDLE;
                        end else if (beat_done) begin
                            word_q <= word_nxt;
                            if (is_eob) begin
                                state_q <= S_IDLE;
                            end else begin
                                ack_q <= 1'b1;
                                dat_q <= mem[word_nxt];
                            end
                        end else if (wb_stb_i) begin
                            // Strobe came back after a pause: re-present the held word.
                            ack_q <= 1'b1;
                            dat_q <= mem[word_q];
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb4_slave_mem.sv
// Directed bench for wb4_slave_mem: one zero-wait and one three-wait instance on a shared,
// gated master bus.
module tb_wb4_slave_mem;

    logic        clk;
    logic        reset;
    logic        tgt;
    logic [31:0] adr;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;

    logic [31:0] dat0, dat1, m_dat;
    logic        ack0, ack1, m_ack;
    logic        err0, err1, m_err;
    logic [1:0]  st0, st1;

    int          checks;
    int          failures;
    int          n;
    logic [31:0] exp3 [4];

    wb4_slave_mem #(.AW(10), .BASE_ADR(32'h0000_1000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_bte_i(bte), .wb_cti_i(cti),
        .wb_cyc_i(cyc & ~tgt), .wb_stb_i(stb & ~tgt), .wb_we_i(we), .wb_sel_i(sel),
        .wb_dat_i(dat_w), .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0),
        .dbg_state_o(st0)
    );

    wb4_slave_mem #(.AW(10), .BASE_ADR(32'h0000_1000), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_bte_i(bte), .wb_cti_i(cti),
        .wb_cyc_i(cyc & tgt), .wb_stb_i(stb & tgt), .wb_we_i(we), .wb_sel_i(sel),
        .wb_dat_i(dat_w), .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1),
        .dbg_state_o(st1)
    );

    assign m_ack = tgt ? ack1 : ack0;
    assign m_err = tgt ? err1 : err0;
    assign m_dat = tgt ? dat1 : dat0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One classic access; rsp = {ack, err} at the first response cycle.
    task automatic classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output int lat, output logic [1:0] rsp);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d; cti = 3'b000; bte = 2'b00;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!m_ack && !m_err && lat < 40);
        rd  = m_dat;
        rsp = {m_ack, m_err};
        @(posedge clk); #1;
        check("pulse_width", {30'b0, m_ack, m_err}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int exp_lat);
        logic [31:0] r;
        int          l;
        logic [1:0]  rsp;
        classic(1'b1, a, s, d, r, l, rsp);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_rsp"}, {30'b0, rsp}, 32'h2);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input int exp_lat);
        logic [31:0] r;
        int          l;
        logic [1:0]  rsp;
        classic(1'b0, a, 4'hF, 32'h0, r, l, rsp);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_rsp"}, {30'b0, rsp}, 32'h2);
        check({tag, "_dat"}, r, exp_d);
    endtask

    task automatic wait_ack(input int limit);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_ack && n < limit);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        logic [1:0]  rsp;
        checks = 0; failures = 0;
        reset = 1'b1; tgt = 1'b0; adr = '0; bte = '0; cti = '0; cyc = 1'b0; stb = 1'b0;
        we = 1'b0; sel = '0; dat_w = '0;
        exp3 = '{32'h3000_0003, 32'h4000_0004, 32'h1234_5678, 32'h2000_0002};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", {31'b0, ack0}, 32'h0);
        check("rst_err0", {31'b0, err0}, 32'h0);
        check("rst_dat0", dat0, 32'h0);
        check("rst_st0", {30'b0, st0}, 32'h0);
        check("rst_ack1", {31'b0, ack1}, 32'h0);
        check("rst_st1", {30'b0, st1}, 32'h0);
        reset = 1'b0;

        // Classic writes then reads, zero wait states.
        do_write("t1_w0", 32'h1000, 32'h1234_5678, 4'hF, 1);
        do_write("t1_w1", 32'h1004, 32'h2000_0002, 4'hF, 1);
        do_write("t1_w2", 32'h1008, 32'h3000_0003, 4'hF, 1);
        do_write("t1_w3", 32'h100C, 32'h4000_0004, 4'hF, 1);
        do_read("t1_r0", 32'h1000, 32'h1234_5678, 1);
        do_read("t1_r1", 32'h1004, 32'h2000_0002, 1);
        do_read("t1_r2", 32'h1008, 32'h3000_0003, 1);
        do_read("t1_r3", 32'h100C, 32'h4000_0004, 1);

        // Byte-lane write, then restore word 0.
        do_write("t2_w", 32'h1000, 32'hAABB_CCDD, 4'b0101, 1);
        do_read("t2_r", 32'h1000, 32'h12BB_56DD, 1);
        do_write("t2_fix", 32'h1000, 32'h1234_5678, 4'hF, 1);

        // Wrap4 read burst from word 2.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h1008; bte = 2'b01; cti = 3'b010;
        wait_ack(20);
        check("t3_lat", n, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ack%0d", i), {31'b0, m_ack}, 32'h1);
            check($sformatf("t3_dat%0d", i), m_dat, exp3[i]);
            @(posedge clk); #1;
            cti = (i == 2) ? 3'b111 : 3'b010;
            adr = 32'h1FF0;
        end
        cyc = 1'b0; stb = 1'b0;
        check("t3_ack_after", {31'b0, m_ack}, 32'h0);

        // Three wait states on the second instance.
        tgt = 1'b1;
        do_write("t4_w", 32'h1004, 32'h2000_0002, 4'hF, 4);
        do_read("t4_r", 32'h1004, 32'h2000_0002, 4);
        tgt = 1'b0;

        // Out-of-window accesses alias word 0 but must not touch it.
        classic(1'b0, 32'h2000, 4'hF, 32'h0, r, l, rsp);
        check("t5_rd_lat", l, 1);
        check("t5_rd_rsp", {30'b0, rsp}, 32'h1);
        check("t5_rd_dat", r, 32'h0);
        classic(1'b1, 32'h2000, 4'hF, 32'hFFFF_FFFF, r, l, rsp);
        check("t5_wr_rsp", {30'b0, rsp}, 32'h1);
        do_read("t5_chk", 32'h1000, 32'h1234_5678, 1);

        // Linear write burst interrupted by reset during the third beat.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h1000; bte = 2'b00; cti = 3'b010;
        dat_w = 32'h6000_0006;
        wait_ack(20);
        check("t6_lat", n, 1);
        @(posedge clk); #1;
        dat_w = 32'h7000_0007;
        @(posedge clk); #1;
        dat_w = 32'h8000_0008;
        check("t6_ack_beat2", {31'b0, m_ack}, 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_ack", {31'b0, m_ack}, 32'h0);
        check("t6_rst_err", {31'b0, m_err}, 32'h0);
        check("t6_rst_st", {30'b0, st0}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_read("t6_r0", 32'h1000, 32'h6000_0006, 1);
        do_read("t6_r1", 32'h1004, 32'h7000_0007, 1);
        do_read("t6_r2", 32'h1008, 32'h3000_0003, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
